// File: rtl/tblink_rpc_cmd_busif.sv
// tblink_rpc_cmd_busif: executes toggle-handshake commands as single 32-bit
// register-bus reads/writes and returns a status/read-data response.
module tblink_rpc_cmd_busif #(
    parameter int CMD_IN_PARAMS_SZ = 8,
    parameter int CMD_IN_RSP_SZ    = 5,
    parameter int TIMEOUT_CYC      = 255
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic [7:0]                    cmd_in,
    input  logic [7:0]                    cmd_in_sz,
    input  logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
    input  logic                          cmd_in_put_i,
    output logic                          cmd_in_get_i,
    output logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
    output logic [7:0]                    cmd_in_rsp_sz,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [31:0]                   bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic                          bus_ack,
    input  logic                          bus_err,
    input  logic [31:0]                   bus_rdata,
    output logic [15:0]                   cmd_count
);
    localparam int W = CMD_IN_RSP_SZ * 8;

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state_q;
    logic          get_q, req_q, we_q;
    logic [W-1:0]  rsp_q, rsp_d;
    logic [7:0]    rsp_sz_q, rsp_sz_d, status_d;
    logic [31:0]   addr_q, wdata_q, rdata_d;
    logic [15:0]   cnt_q, tmo_q;
    logic          pend, bus_cmd, ack, tmo_hit, rd_ok, done;
    logic          unused_ok;

    assign unused_ok = ^{cmd_in_sz, cmd_in_params};

    always_comb begin
        pend     = cmd_in_put_i != get_q;
        bus_cmd  = cmd_in == 8'h01 || cmd_in == 8'h02;
        ack      = state_q == BUS && bus_ack;
        // Ack takes priority over a timeout expiring on the same edge.
        tmo_hit  = state_q == BUS && TIMEOUT_CYC != 0 && tmo_q + 16'd1 == 16'(TIMEOUT_CYC);
        done     = (state_q == IDLE && pend && !bus_cmd) || ack || tmo_hit;
        rd_ok    = ack && !we_q && !bus_err;
        status_d = state_q == IDLE ? (cmd_in == 8'h03 ? 8'h00 : 8'h02)
                 : ack ? {7'b0, bus_err} : 8'h03;
        rdata_d  = rd_ok ? bus_rdata : 32'h0;
        rsp_sz_d = rd_ok ? 8'd5 : 8'd1;
        rsp_d    = '0;
        rsp_d[39:0] = {rdata_d, status_d};
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            get_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            rsp_q    <= '0;
            rsp_sz_q <= 8'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= 16'h0;
            tmo_q    <= 16'h0;
        end else begin
            if (state_q == IDLE) begin
                if (pend && bus_cmd) begin
                    state_q <= BUS;
                    req_q   <= 1'b1;
                    we_q    <= cmd_in == 8'h01;
                    addr_q  <= cmd_in_params[31:0];
                    tmo_q   <= 16'h0;
                    if (cmd_in == 8'h01)
                        wdata_q <= cmd_in_params[63:32];
                end
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (done) begin
                state_q  <= IDLE;
                get_q    <= ~get_q;
                req_q    <= 1'b0;
                rsp_q    <= rsp_d;
                rsp_sz_q <= rsp_sz_d;
                cnt_q    <= cnt_q + 16'd1;
            end
        end
    end

    assign cmd_in_get_i  = get_q;
    assign cmd_in_rsp    = rsp_q;
    assign cmd_in_rsp_sz = rsp_sz_q;
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign cmd_count     = cnt_q;
endmodule

// File: tb/tb_tblink_rpc_cmd_busif.sv
// tb_tblink_rpc_cmd_busif: directed and randomized checks of the command
// executor against a transaction-level expectation model.
module tb_tblink_rpc_cmd_busif;
    localparam int TMO = 4;

    logic        uclock = 0;
    logic        reset;
    logic [7:0]  cmd_in, cmd_in_sz;
    logic [63:0] cmd_in_params;
    logic        cmd_in_put_i;
    logic        cmd_in_get_i;
    logic [39:0] cmd_in_rsp;
    logic [7:0]  cmd_in_rsp_sz;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [15:0] cmd_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 0;
    logic [31:0] exp_wdata = 0;

    tblink_rpc_cmd_busif #(.CMD_IN_PARAMS_SZ(8), .CMD_IN_RSP_SZ(5), .TIMEOUT_CYC(TMO)) dut (
        .uclock(uclock), .reset(reset), .cmd_in(cmd_in), .cmd_in_sz(cmd_in_sz),
        .cmd_in_params(cmd_in_params), .cmd_in_put_i(cmd_in_put_i), .cmd_in_get_i(cmd_in_get_i),
        .cmd_in_rsp(cmd_in_rsp), .cmd_in_rsp_sz(cmd_in_rsp_sz), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata), .cmd_count(cmd_count)
    );

    always #5 uclock = ~uclock;

    task automatic step();
        @(posedge uclock);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        cmd_in        = c;
        cmd_in_sz     = 8'd8;
        cmd_in_params = {d, a};
        cmd_in_put_i  = ~cmd_in_put_i;
    endtask

    // Bus command: ack offered after `waits` BUS cycles when ack_en, else never.
    task automatic run_bus(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input bit err, input logic [31:0] rd,
                           input bit ack_en, input string tag);
        int          n = 0;
        int          exp_n;
        logic [7:0]  exp_st;
        logic [31:0] exp_data;
        bit          acked = ack_en && waits < TMO;
        exp_n    = acked ? waits + 1 : TMO;
        exp_st   = acked ? {7'b0, err} : 8'h03;
        exp_data = (c == 8'h02 && exp_st == 8'h00) ? rd : 32'h0;
        if (c == 8'h01) exp_wdata = d;
        issue(c, a, d);
        step();
        total++;
        if (bus_req !== 1'b1 || bus_addr !== a || bus_we !== (c == 8'h01) || bus_wdata !== exp_wdata) begin
            bad++;
            $display("FAIL %s bus_setup got req=%b we=%b addr=%h wdata=%h want req=1 we=%b addr=%h wdata=%h",
                     tag, bus_req, bus_we, bus_addr, bus_wdata, c == 8'h01, a, exp_wdata);
        end
        for (int cyc = 0; cyc < 50 && bus_req === 1'b1; cyc++) begin
            bus_ack   = ack_en && n == waits;
            bus_err   = err;
            bus_rdata = rd;
            step();
            n++;
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
        end
        exp_cnt++;
        total++;
        if (n !== exp_n) begin
            bad++;
            $display("FAIL %s req_cycles got=%0d want=%0d", tag, n, exp_n);
        end
        total++;
        if (cmd_in_rsp !== {exp_data, exp_st} || cmd_in_rsp_sz !== ((c == 8'h02 && exp_st == 8'h00) ? 8'd5 : 8'd1)) begin
            bad++;
            $display("FAIL %s rsp got=%h sz=%0d want=%h sz=%0d", tag, cmd_in_rsp, cmd_in_rsp_sz,
                     {exp_data, exp_st}, (c == 8'h02 && exp_st == 8'h00) ? 5 : 1);
        end
        total++;
        if (cmd_in_get_i !== cmd_in_put_i || cmd_count !== exp_cnt) begin
            bad++;
            $display("FAIL %s handshake got get=%b cnt=%h want get=%b cnt=%h", tag, cmd_in_get_i,
                     cmd_count, cmd_in_put_i, exp_cnt);
        end
    endtask

    task automatic run_simple(input logic [7:0] c, input string tag);
        logic [7:0] exp_st = c == 8'h03 ? 8'h00 : 8'h02;
        issue(c, $urandom, $urandom);
        total++;
        if (cmd_in_get_i === cmd_in_put_i) begin
            bad++;
            $display("FAIL %s early_get got=%b want=%b", tag, cmd_in_get_i, ~cmd_in_put_i);
        end
        step();
        exp_cnt++;
        total++;
        if (cmd_in_get_i !== cmd_in_put_i || cmd_in_rsp !== {32'h0, exp_st} || cmd_in_rsp_sz !== 8'd1
            || bus_req !== 1'b0 || cmd_count !== exp_cnt) begin
            bad++;
            $display("FAIL %s rsp got get=%b rsp=%h sz=%0d req=%b cnt=%h want get=%b rsp=%h sz=1 req=0 cnt=%h",
                     tag, cmd_in_get_i, cmd_in_rsp, cmd_in_rsp_sz, bus_req, cmd_count,
                     cmd_in_put_i, {32'h0, exp_st}, exp_cnt);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (cmd_in_get_i !== 1'b0 || cmd_in_rsp !== 40'h0 || cmd_in_rsp_sz !== 8'h0 || bus_req !== 1'b0
            || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || cmd_count !== 16'h0) begin
            bad++;
            $display("FAIL %s got get=%b rsp=%h sz=%h req=%b we=%b addr=%h wdata=%h cnt=%h want all zero",
                     tag, cmd_in_get_i, cmd_in_rsp, cmd_in_rsp_sz, bus_req, bus_we, bus_addr, bus_wdata, cmd_count);
        end
    endtask

    task automatic test_reset();
        reset = 1; cmd_in_put_i = 0; cmd_in = 0; cmd_in_sz = 0; cmd_in_params = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        step(); step();
        check_reset_vals("reset");
        reset = 0;
        step();
        check_reset_vals("reset_idle");
    endtask

    task automatic test_write();
        run_bus(8'h01, 32'h1000_0004, 32'hDEAD_BEEF, 3, 0, 0, 1, "write");
    endtask

    task automatic test_read();
        run_bus(8'h02, 32'h0000_0020, 32'h5555_AAAA, 0, 0, 32'h1234_5678, 1, "read");
        run_bus(8'h02, 32'h0000_0024, 32'h0, 2, 1, 32'hCAFE_F00D, 1, "read_err");
        run_simple(8'h7F, "bad_cmd");
    endtask

    task automatic test_timeout();
        run_bus(8'h02, 32'h40, 32'h0, 0, 0, 32'h1, 0, "timeout");
        run_bus(8'h01, 32'h44, 32'h0BAD_F00D, 3, 0, 32'h0, 1, "ack_at_limit");
    endtask

    task automatic test_back_to_back();
        logic [15:0] base = exp_cnt;
        run_simple(8'h03, "b2b_ping");
        run_bus(8'h01, 32'h80, 32'h1357_9BDF, 0, 0, 0, 1, "b2b_write");
        total++;
        if (cmd_count !== base + 16'd2) begin
            bad++;
            $display("FAIL b2b_count got=%h want=%h", cmd_count, base + 16'd2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 3);
            if (k == 0) run_simple(8'h03, "rnd_ping");
            else if (k == 1) run_simple(8'h04 + 8'($urandom_range(0, 250)), "rnd_bad");
            else run_bus(k == 2 ? 8'h01 : 8'h02, $urandom, $urandom, $urandom_range(0, 6),
                         1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4) != 0, "rnd_bus");
        end
    endtask

    task automatic test_wrap();
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFE;
        run_simple(8'h03, "wrap_ffff");
        run_simple(8'h03, "wrap_zero");
    endtask

    task automatic test_reset_mid_bus();
        issue(8'h02, 32'h99, 32'h0);
        step(); step();
        #2;
        reset = 1;
        #1;
        check_reset_vals("reset_mid_bus");
        step();
        check_reset_vals("reset_held");
        cmd_in_put_i = 0;
        reset = 0;
        exp_cnt = 0;
        exp_wdata = 0;
        step();
        check_reset_vals("reset_no_toggle");
        run_simple(8'h03, "ping_after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
